mm_result_drain: RTL and testbench
==================================

Name: mm_result_drain

Overview:
- Downstream stage of the sum-stationary N x N matrix-multiply engine.
- Captures each complete C matrix (N*N words, presented for one cycle with a valid pulse) into a 2-entry ping-pong buffer.
- Streams each captured matrix out one row (N words) per beat over a valid/ready handshake.
- Decouples the engine, which has no backpressure, from a consumer that may stall; flags dropped matrices.

Parameters:
- DATA_WIDTH, 8, operand width of the upstream engine (used only to derive C_DATA_WIDTH).
- N, 4, matrix dimension; N >= 2.
- C_DATA_WIDTH, (2*DATA_WIDTH)+$clog2(N) = 18, width of one C element.

Ports:
- clk_i  input  1  single clock; all logic on rising edge.
- reset_i  input  1  synchronous, active-high reset.
- valid_i  input  1  single-cycle pulse: c_i holds a complete result matrix.
- c_i  input  [C_DATA_WIDTH-1:0] x [N*N]  result matrix, element (r,col) at index r*N+col.
- full_o  output  1  high when both buffer entries are occupied.
- overflow_o  output  1  sticky: a valid_i pulse was dropped.
- valid_o  output  1  row_o/row_idx_o/last_o are valid.
- ready_i  input  1  consumer accepts the current row.
- row_o  output  [C_DATA_WIDTH-1:0] x [N]  current row, column 0 at index 0.
- row_idx_o  output  max(1,$clog2(N))  index of the current row, 0..N-1.
- last_o  output  1  current row is row N-1 of its matrix.

Behaviour:
- Reset values (cycle after reset_i sampled high):
  - count=0, write and read pointers=0, row index=0.
  - valid_o=0, full_o=0, overflow_o=0, last_o=0, row_idx_o=0, row_o all zeros.
  - Buffer storage is not cleared.
  - Reset mid-drain or mid-capture discards all held matrices with no partial output.
- Storage: 2 entries of N*N words. count in {0,1,2}; full_o = (count==2), registered.
- Capture:
  - On a clock edge with valid_i=1 and registered count<2: c_i is written to entry wr_ptr, wr_ptr toggles, count increments.
  - Acceptance depends only on the registered count. A slot freed by a pop in the same cycle does not make room for that cycle's capture.
  - valid_i=1 while count==2: matrix dropped, no state change, overflow_o set next cycle and held until reset.
- Output:
  - valid_o = (count>0).
  - row_o = entry rd_ptr, row row_idx_o; all zeros when valid_o=0.
  - last_o = valid_o && (row_idx_o==N-1).
  - Outputs are combinational from registered state and stay stable while valid_o=1 and ready_i=0.
  - ready_i is ignored when valid_o=0.
- Beat transfer (valid_o && ready_i at an edge):
  - If row_idx_o<N-1: row_idx_o increments.
  - Otherwise: row_idx_o returns to 0, rd_ptr toggles, count decrements (pop).
- Simultaneous capture and pop: count unchanged, both pointers advance.
- Latency: with an empty buffer, capture at edge t gives valid_o=1 and row 0 in the cycle after t. With ready_i held high, rows 0..N-1 occupy N consecutive cycles; the next matrix, if buffered, follows with no bubble.
- Back-to-back valid_i pulses on consecutive cycles: the first two are accepted, a third before any pop is dropped.
- No combinational path from ready_i to full_o or to capture acceptance.

Test Plan:
- Reset, then one pulse with c_i[k]=k+1, ready_i=1:
  - Next cycle, valid_o=1 with row_o={1,2,3,4}, row_idx_o=0.
  - Then {5,6,7,8}, {9,10,11,12}, then {13,14,15,16} with last_o=1.
  - Then valid_o=0; overflow_o stays 0.
- Backpressure: capture the same matrix, hold ready_i=0 for 5 cycles, then toggle ready_i 1/0.
  - row_o stays {1,2,3,4} while stalled.
  - Each row advances only on cycles where ready_i=1; 4 beats total.
- Ping-pong with ready_i=0: pulse M1 (k+1), then M2 (k+101) on the next cycle.
  - full_o=1.
  - A third pulse M3 sets overflow_o=1.
  - With ready_i=1, 8 rows stream out: M1 then M2 ({101..104} first); M3 never appears.
- Simultaneous events: with count=2 and row 3 of M1 being accepted, pulse M3 in the same cycle.
  - M3 is dropped, overflow_o=1, count becomes 1.
  - Repeat with count=1: M3 is captured and count stays 1.
- Reset mid-drain: after 2 of 4 rows are accepted, assert reset_i for 1 cycle.
  - Next cycle, valid_o=0, full_o=0, overflow_o=0, row_idx_o=0.
  - A new pulse with c_i[k]=k+50 drains starting at {50,51,52,53}.

Source files
------------

// File: rtl/mm_result_drain.sv
// mm_result_drain: ping-pong capture of N x N result matrices, drained one row per handshake beat
module mm_result_drain #(
  parameter int DATA_WIDTH   = 8,
  parameter int N            = 4,
  parameter int C_DATA_WIDTH = (2*DATA_WIDTH)+$clog2(N),
  localparam int RW          = (N > 2) ? $clog2(N) : 1
)(
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    valid_i,
  input  logic [C_DATA_WIDTH-1:0] c_i [N*N],
  output logic                    full_o,
  output logic                    overflow_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [C_DATA_WIDTH-1:0] row_o [N],
  output logic [RW-1:0]           row_idx_o,
  output logic                    last_o
);
  localparam int AW = $clog2(N*N);
  logic [C_DATA_WIDTH-1:0] r_mem [2][N*N];
  logic [1:0]              r_count;
  logic                    r_wr;
  logic                    r_rd;
  logic [RW-1:0]           r_row_idx;
  logic                    r_ovf;
  logic                    w_push;
  logic                    w_beat;
  logic                    w_pop;
  logic                    w_last_row;
  assign w_push     = valid_i && (r_count != 2'd2);
  assign w_last_row = r_row_idx == RW'(N-1);
  assign w_beat     = valid_o && ready_i;
  assign w_pop      = w_beat && w_last_row;
  assign valid_o    = r_count != 2'd0;
  assign full_o     = r_count == 2'd2;
  assign overflow_o = r_ovf;
  assign last_o     = valid_o && w_last_row;
  assign row_idx_o  = r_row_idx;
  // present the current row of the head entry, zeros when nothing is held
  always_comb begin
    for (int c = 0; c < N; c++)
      row_o[c] = valid_o ? r_mem[r_rd][AW'(int'(r_row_idx)*N + c)] : '0;
  end
  // matrix storage; never cleared, only overwritten on accepted captures
  always_ff @(posedge clk_i) begin
    if (w_push)
      for (int k = 0; k < N*N; k++)
        r_mem[r_wr][k] <= c_i[k];
  end
  // occupancy, pointers, row cursor and sticky drop flag
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_count   <= 2'd0;
      r_wr      <= 1'b0;
      r_rd      <= 1'b0;
      r_row_idx <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_count   <= r_count + 2'(w_push) - 2'(w_pop);
      r_wr      <= w_push ? ~r_wr : r_wr;
      r_rd      <= w_pop ? ~r_rd : r_rd;
      r_row_idx <= w_beat ? (w_last_row ? '0 : r_row_idx + 1'b1) : r_row_idx;
      r_ovf     <= r_ovf || (valid_i && !w_push);
    end
  end
endmodule

// File: tb/tb_mm_result_drain.sv
// tb_mm_result_drain: scoreboard bench comparing the drain against a row-queue reference model
module tb_mm_result_drain;
  localparam int DW = 8;
  localparam int N  = 4;
  localparam int CW = (2*DW)+$clog2(N);
  localparam int RW = 2;
  typedef logic [N*CW-1:0] row_t;
  logic          clk = 0;
  logic          reset_i = 1;
  logic          valid_i = 0;
  logic [CW-1:0] c_i [N*N];
  logic          full_o;
  logic          overflow_o;
  logic          valid_o;
  logic          ready_i = 0;
  logic [CW-1:0] row_o [N];
  logic [RW-1:0] row_idx_o;
  logic          last_o;
  int total = 0;
  int bad = 0;
  row_t exp_q[$];
  int   mcnt = 0;
  int   mrow = 0;
  bit   movf = 0;
  bit   armed = 0;

  mm_result_drain #(.DATA_WIDTH(DW), .N(N)) dut (
    .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .c_i(c_i),
    .full_o(full_o), .overflow_o(overflow_o), .valid_o(valid_o),
    .ready_i(ready_i), .row_o(row_o), .row_idx_o(row_idx_o), .last_o(last_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input row_t got, input row_t want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic step(input bit v, input bit r, input int base);
    valid_i = v;
    ready_i = r;
    for (int k = 0; k < N*N; k++) c_i[k] = CW'(base + k);
    @(posedge clk);
    #1;
    valid_i = 0;
  endtask

  // reference model: matrices become N queued rows; two matrices max, acceptance judged before any pop
  always @(posedge clk) begin
    bit beat, acc;
    row_t rw;
    if (reset_i) begin
      exp_q.delete();
      mcnt = 0; mrow = 0; movf = 0; armed = 1;
    end else if (armed) begin
      beat = (exp_q.size() > 0) && ready_i;
      acc  = valid_i && (mcnt < 2);
      if (valid_i && !acc) movf = 1;
      if (beat) begin
        void'(exp_q.pop_front());
        if (mrow == N-1) begin mrow = 0; mcnt--; end else mrow++;
      end
      if (acc) begin
        for (int r = 0; r < N; r++) begin
          for (int c = 0; c < N; c++) rw[c*CW +: CW] = c_i[r*N + c];
          exp_q.push_back(rw);
        end
        mcnt++;
      end
    end
  end

  // monitor: compare presented outputs against the head of the expected row queue
  always @(negedge clk) begin
    row_t got;
    if (armed && !reset_i) begin
      for (int c = 0; c < N; c++) got[c*CW +: CW] = row_o[c];
      check("valid_o", row_t'(valid_o), row_t'(exp_q.size() > 0));
      check("full_o", row_t'(full_o), row_t'(mcnt == 2));
      check("overflow_o", row_t'(overflow_o), row_t'(movf));
      check("row_idx_o", row_t'(row_idx_o), row_t'(mrow));
      check("last_o", row_t'(last_o), row_t'(exp_q.size() > 0 && mrow == N-1));
      check("row_o", got, exp_q.size() > 0 ? exp_q[0] : '0);
    end
  end

  initial begin
    for (int k = 0; k < N*N; k++) c_i[k] = '0;
    step(0, 0, 0);
    step(0, 0, 0);
    reset_i = 0;
    step(0, 0, 0);
    step(1, 1, 1);
    repeat (6) step(0, 1, 0);
    step(1, 0, 1);
    repeat (5) step(0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, i % 2 == 0, 0);
    step(1, 0, 1);
    step(1, 0, 101);
    step(1, 0, 201);
    repeat (2) step(0, 0, 0);
    repeat (10) step(0, 1, 0);
    reset_i = 1;
    step(0, 0, 0);
    reset_i = 0;
    step(1, 0, 1);
    step(1, 0, 101);
    repeat (3) step(0, 1, 0);
    step(1, 1, 201);
    repeat (3) step(0, 1, 0);
    step(1, 1, 301);
    repeat (6) step(0, 1, 0);
    step(1, 0, 1);
    repeat (2) step(0, 1, 0);
    reset_i = 1;
    step(0, 0, 0);
    reset_i = 0;
    step(1, 1, 50);
    repeat (6) step(0, 1, 0);
    for (int i = 0; i < 1500; i++) begin
      reset_i = ($urandom_range(0, 199) == 0);
      step($urandom_range(0, 2) == 0, $urandom_range(0, 2) != 0, int'($urandom_range(0, 100000)));
    end
    reset_i = 0;
    repeat (12) step(0, 1, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
